// File: rtl/ysyx_23060171_exu_pkg.sv
// Shared types for the execute stage: op encoding, FSM states and op-class helpers.
package ysyx_23060171_exu_pkg;

  localparam int unsigned XLEN_DEF = 32;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } exu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } exu_state_e;

  function automatic logic is_muldiv(input exu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_div(input exu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input exu_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_mulh(input exu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic a_signed(input exu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(input exu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ysyx_23060171_exu_md_if.sv
// Upstream/downstream handshake bundle of the execute stage.
interface ysyx_23060171_exu_md_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 64
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_imm;
  logic             in_srca;
  logic             in_srcb;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output flush, in_valid, in_op, in_rs1, in_rs2, in_pc, in_imm,
           in_srca, in_srcb, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_rs1, in_rs2, in_pc, in_imm,
           in_srca, in_srcb, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/ysyx_23060171_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider on operand magnitudes,
// STEP_BITS per cycle; sign correction applied to the final step's value.
module ysyx_23060171_muldiv_iter #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic            is_div_i,
  input  logic            hi_sel_i,
  input  logic            neg_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_c,
  output logic [XLEN-1:0] result_c
);
  localparam int unsigned STEPS = XLEN / STEP_BITS;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  logic            run_q, is_div_q, hi_sel_q, neg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, b_q, hi_n, lo_n, sel;
  logic [XLEN:0]   tmp;
  logic [2*XLEN-1:0] prod;

  // hi/lo hold {partial product, multiplier} for mul and {remainder, dividend/quotient} for div
  always_comb begin
    hi_n = hi_q;
    lo_n = lo_q;
    tmp  = '0;
    for (int unsigned s = 0; s < STEP_BITS; s++) begin
      if (is_div_q) begin
        tmp = {hi_n, lo_n[XLEN-1]} - {1'b0, b_q};
        if (!tmp[XLEN]) begin
          hi_n = tmp[XLEN-1:0];
          lo_n = {lo_n[XLEN-2:0], 1'b1};
        end else begin
          hi_n = {hi_n[XLEN-2:0], lo_n[XLEN-1]};
          lo_n = {lo_n[XLEN-2:0], 1'b0};
        end
      end else begin
        tmp = {1'b0, hi_n} + (lo_n[0] ? {1'b0, b_q} : '0);
        {hi_n, lo_n} = {tmp, lo_n[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod = {hi_n, lo_n};
    if (neg_q && !is_div_q) prod = -prod;
    sel = hi_sel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    if (neg_q && is_div_q) sel = -sel;
    result_c = sel;
  end

  assign done_c = run_q && (cnt_q == CNT_W'(STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      hi_sel_q <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
    end else if (kill_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      is_div_q <= is_div_i;
      hi_sel_q <= hi_sel_i;
      neg_q    <= neg_i;
      hi_q     <= '0;
      lo_q     <= a_i;
      b_q      <= b_i;
    end else if (run_q) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
      if (done_c) begin
        run_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/ysyx_23060171_exu_md.sv
// Handshaked execute stage: operand select, single-cycle ALU, iterative RV32M unit,
// registered result/tag with valid/ready backpressure and flush.
module ysyx_23060171_exu_md
  import ysyx_23060171_exu_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEF,
  parameter int unsigned STEP_BITS = 1,
  parameter int unsigned TAG_W     = 64
) (
  input logic clk,
  input logic rst_n,
  ysyx_23060171_exu_md_if.slave bus
);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  exu_op_e          op;
  exu_state_e       state_q, state_d;
  logic [XLEN-1:0]  opa, opb, alu_c, fast_res_c, a_mag, b_mag, md_res_c;
  logic [XLEN-1:0]  out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_valid_q, out_valid_d, busy_q, busy_d;
  logic             dz, ovf, a_neg, b_neg, md_neg, md_hi, start_c, md_done_c, accept;
  logic [SHW-1:0]   shamt;

  assign op    = exu_op_e'(bus.in_op);
  assign opa   = bus.in_srca ? bus.in_pc : bus.in_rs1;
  assign opb   = bus.in_srcb ? bus.in_imm : bus.in_rs2;
  assign shamt = opb[SHW-1:0];

  assign bus.in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // Unknown encodings fall through to ADD
  always_comb begin
    case (op)
      OP_SUB:  alu_c = opa - opb;
      OP_SLL:  alu_c = opa << shamt;
      OP_SLT:  alu_c = XLEN'($signed(opa) < $signed(opb));
      OP_SLTU: alu_c = XLEN'(opa < opb);
      OP_XOR:  alu_c = opa ^ opb;
      OP_SRL:  alu_c = opa >> shamt;
      OP_SRA:  alu_c = XLEN'($signed(opa) >>> shamt);
      OP_OR:   alu_c = opa | opb;
      OP_AND:  alu_c = opa & opb;
      default: alu_c = opa + opb;
    endcase
  end

  assign a_neg  = a_signed(op) && opa[XLEN-1];
  assign b_neg  = b_signed(op) && opb[XLEN-1];
  assign a_mag  = a_neg ? -opa : opa;
  assign b_mag  = b_neg ? -opb : opb;
  assign md_neg = is_rem(op) ? a_neg : (a_neg ^ b_neg);
  assign md_hi  = is_rem(op) || is_mulh(op);

  // Divide-by-zero and signed overflow resolve in one cycle without iterating
  assign dz  = is_div(op) && (opb == '0);
  assign ovf = (op == OP_DIV || op == OP_REM) && (opa == SMIN) && (&opb);

  always_comb begin
    fast_res_c = alu_c;
    if (dz)       fast_res_c = is_rem(op) ? opa : '1;
    else if (ovf) fast_res_c = is_rem(op) ? '0 : opa;
  end

  ysyx_23060171_muldiv_iter #(.XLEN(XLEN), .STEP_BITS(STEP_BITS)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_c),
    .kill_i   (bus.flush),
    .is_div_i (is_div(op)),
    .hi_sel_i (md_hi),
    .neg_i    (md_neg),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .done_c   (md_done_c),
    .result_c (md_res_c)
  );

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    busy_d       = busy_q;
    start_c      = 1'b0;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (bus.flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            out_tag_d = bus.in_tag;
            if (is_muldiv(op) && !dz && !ovf) begin
              state_d = S_CALC;
              busy_d  = 1'b1;
              start_c = 1'b1;
            end else begin
              out_valid_d  = 1'b1;
              out_result_d = fast_res_c;
            end
          end
        end
        S_CALC: begin
          if (md_done_c) begin
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            out_valid_d  = 1'b1;
            out_result_d = md_res_c;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_ysyx_23060171_exu_md.sv
// Directed testbench for ysyx_23060171_exu_md with hand-computed expectations.
module tb_ysyx_23060171_exu_md;
  import ysyx_23060171_exu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    logic [31:0] exp;
  } vec_t;

  vec_t v[16];
  int   nv;

  ysyx_23060171_exu_md_if #(.XLEN(32), .TAG_W(64)) bus ();

  ysyx_23060171_exu_md #(.XLEN(32), .STEP_BITS(1), .TAG_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb, input logic [63:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_srca  = sa;
    bus.in_srcb  = sb;
    bus.in_rs1   = sa ? 32'hDEAD_BEEF : a;
    bus.in_pc    = sa ? a : 32'h1234_5678;
    bus.in_rs2   = sb ? 32'hCAFE_F00D : b;
    bus.in_imm   = sb ? b : 32'h0BAD_0BAD;
    bus.in_tag   = tag;
  endtask

  task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sa, input logic sb, input logic [31:0] exp);
    v[nv] = '{op, a, b, sa, sb, exp};
    nv++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_op = 5'd0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_pc = '0; bus.in_imm = '0;
    bus.in_srca = 1'b0; bus.in_srcb = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b1;
    #12;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: valid=%b busy=%b exp 0 0", bus.out_valid, bus.busy);
    end
    n_tests++;
    if (bus.out_result !== 32'h0 || bus.out_tag !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: result=%h tag=%h exp 0 0", bus.out_result, bus.out_tag);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    drive(OP_ADD, 32'd5, 32'd7, 1'b0, 1'b0, 64'hA5A5_0000_0000_0001);
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_in_ready: got %b exp 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd12 || bus.out_tag !== 64'hA5A5_0000_0000_0001) begin
      n_fail++; $display("FAIL add_result: valid=%b result=%h tag=%h exp 1 0000000c a5a5000000000001",
                         bus.out_valid, bus.out_result, bus.out_tag);
    end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_consumed: valid=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    nv = 0;
    add_vec(OP_SUB,  32'd10,        32'd3,         1'b0, 1'b0, 32'd7);
    add_vec(OP_SLT,  32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 32'd1);
    add_vec(OP_SRA,  32'h8000_0000, 32'd4,         1'b0, 1'b0, 32'hF800_0000);
    add_vec(OP_SLTU, 32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 32'd0);
    add_vec(OP_SLT,  32'd1,         32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    add_vec(OP_SLL,  32'd1,         32'd33,        1'b0, 1'b0, 32'd2);
    add_vec(OP_SRL,  32'h8000_0000, 32'd31,        1'b0, 1'b0, 32'd1);
    add_vec(OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b0, 32'h0FF0_0FF0);
    add_vec(OP_OR,   32'h0000_000F, 32'h0000_00F0, 1'b0, 1'b0, 32'h0000_00FF);
    add_vec(OP_AND,  32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 1'b0, 32'h0000_00F0);
    add_vec(OP_ADD,  32'h0000_1000, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0FFC);
    add_vec(5'd12,   32'd3,         32'd4,         1'b0, 1'b0, 32'd7);
    for (int i = 0; i < nv; i++) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].sa, v[i].sb, 64'h100 + 64'(i));
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== v[i].exp || bus.out_tag !== 64'h100 + 64'(i)) begin
        n_fail++; $display("FAIL b2b_vec%0d: valid=%b result=%h tag=%h exp 1 %h %h",
                           i, bus.out_valid, bus.out_result, bus.out_tag, v[i].exp, 64'h100 + 64'(i));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: valid=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_div_special();
    nv = 0;
    add_vec(OP_DIV,  32'd7,         32'd0,         1'b0, 1'b0, 32'hFFFF_FFFF);
    add_vec(OP_REM,  32'd7,         32'd0,         1'b0, 1'b0, 32'd7);
    add_vec(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000);
    add_vec(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    add_vec(OP_DIVU, 32'd5,         32'd0,         1'b0, 1'b0, 32'hFFFF_FFFF);
    add_vec(OP_REMU, 32'd5,         32'd0,         1'b0, 1'b0, 32'd5);
    for (int i = 0; i < nv; i++) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].sa, v[i].sb, 64'h200 + 64'(i));
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== v[i].exp || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL divspecial_vec%0d: valid=%b result=%h busy=%b exp 1 %h 0",
                           i, bus.out_valid, bus.out_result, bus.busy, v[i].exp);
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_muldiv();
    int cyc;
    nv = 0;
    add_vec(OP_MUL,    32'hFFFF_FFFF, 32'd3,         1'b0, 1'b0, 32'hFFFF_FFFD);
    add_vec(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFF);
    add_vec(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE);
    add_vec(OP_DIV,    32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0, 32'hFFFF_FFFD);
    add_vec(OP_DIVU,   32'd100,       32'd7,         1'b0, 1'b0, 32'd14);
    add_vec(OP_REM,    32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 32'd1);
    add_vec(OP_REMU,   32'd100,       32'd7,         1'b0, 1'b0, 32'd2);
    add_vec(OP_MUL,    32'd6,         32'd7,         1'b1, 1'b1, 32'd42);
    for (int i = 0; i < nv; i++) begin
      drive(v[i].op, v[i].a, v[i].b, v[i].sa, v[i].sb, 64'h300 + 64'(i));
      tick();
      bus.in_valid = 1'b0;
      cyc = 1;
      while (!bus.out_valid && cyc < 40) begin
        tick();
        cyc++;
      end
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== v[i].exp || cyc != 33) begin
        n_fail++; $display("FAIL muldiv_vec%0d: valid=%b result=%h latency=%0d exp 1 %h 33",
                           i, bus.out_valid, bus.out_result, cyc, v[i].exp);
      end
      tick();
    end
  endtask

  task automatic test_mulh();
    int lat, busy_cnt, ir_bad;
    drive(OP_MULH, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 64'h0000_0000_0000_0400);
    tick();
    bus.in_valid = 1'b0;
    lat = 1; busy_cnt = 0; ir_bad = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.busy) busy_cnt++;
      if (bus.in_ready) ir_bad++;
      tick();
      lat++;
    end
    n_tests++;
    if (lat != 33) begin
      n_fail++; $display("FAIL mulh_latency: got %0d exp 33", lat);
    end
    n_tests++;
    if (busy_cnt != 32 || ir_bad != 0) begin
      n_fail++; $display("FAIL mulh_busy: busy_cycles=%0d in_ready_cycles=%0d exp 32 0", busy_cnt, ir_bad);
    end
    n_tests++;
    if (bus.out_result !== 32'h4000_0000 || bus.out_tag !== 64'h400 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL mulh_result: result=%h tag=%h busy=%b exp 40000000 400 0",
                         bus.out_result, bus.out_tag, bus.busy);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int cyc;
    bus.out_ready = 1'b0;
    drive(OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 64'h0000_0000_0000_0500);
    tick();
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFFFF_FFFF || cyc != 33) begin
      n_fail++; $display("FAIL bp_rem: valid=%b result=%h latency=%0d exp 1 ffffffff 33",
                         bus.out_valid, bus.out_result, cyc);
    end
    drive(OP_ADD, 32'd1, 32'd1, 1'b0, 1'b0, 64'h501);
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFFFF_FFFF ||
          bus.out_tag !== 64'h500 || bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: valid=%b result=%h tag=%h in_ready=%b exp 1 ffffffff 500 0",
                           k, bus.out_valid, bus.out_result, bus.out_tag, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %b exp 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd2 || bus.out_tag !== 64'h501) begin
      n_fail++; $display("FAIL bp_next: valid=%b result=%h tag=%h exp 1 2 501",
                         bus.out_valid, bus.out_result, bus.out_tag);
    end
    tick();
  endtask

  task automatic test_flush();
    int cnt;
    drive(OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 64'h600);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre_busy: got %b exp 1", bus.busy);
    end
    bus.flush = 1'b1;
    drive(OP_ADD, 32'd20, 32'd22, 1'b0, 1'b0, 64'h601);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_in_ready: got %b exp 0", bus.in_ready);
    end
    tick();
    bus.flush = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_kill: busy=%b valid=%b exp 0 0", bus.busy, bus.out_valid);
    end
    tick();
    bus.in_valid = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd42 || bus.out_tag !== 64'h601) begin
      n_fail++; $display("FAIL flush_add_after: valid=%b result=%h tag=%h exp 1 2a 601",
                         bus.out_valid, bus.out_result, bus.out_tag);
    end
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.out_valid) cnt++;
    end
    n_tests++;
    if (cnt != 0) begin
      n_fail++; $display("FAIL flush_no_stale: valid_cycles=%0d exp 0", cnt);
    end
  endtask

  task automatic test_async_reset();
    int cnt;
    drive(OP_MUL, 32'd6, 32'd7, 1'b0, 1'b0, 64'h700);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre_busy: got %b exp 1", bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_tag !== 64'h0) begin
      n_fail++; $display("FAIL areset_abort: busy=%b valid=%b tag=%h exp 0 0 0",
                         bus.busy, bus.out_valid, bus.out_tag);
    end
    #2 rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.out_valid) cnt++;
    end
    n_tests++;
    if (cnt != 0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL areset_no_result: valid_cycles=%0d in_ready=%b exp 0 1", cnt, bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_div_special();
    test_muldiv();
    test_mulh();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
